// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: shared types and helpers for the APB SRAM slave.
//   state_t     - transfer FSM states (IDLE, ACCESS)
//   ERR_*       - bit positions of the individual error causes, kept
//                 separate so coverage can see why a transfer failed
//   merge_lanes - byte-lane merge of new write data into an old word
package apb_sram_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RO    = 2;
  localparam int ERR_W     = 3;

  // Sized for the widest legal bus (64 bits / 8 lanes); narrower callers
  // zero-extend their operands and truncate the result.
  function automatic logic [63:0] merge_lanes(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  strb);
    logic [63:0] res;
    res = old_word;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_sram_mem.sv
// apb_sram_mem: DEPTH x DATA_WIDTH flop array.
//   clk, rst  - clock, async active-high reset (loads mem[i] = i)
//   rd_idx    - combinational read address, rd_data - read word
//   wr_en     - commit write at the rising edge
//   wr_idx, wr_data, wr_strb - write word index, data, byte-lane enables
module apb_sram_mem
  import apb_sram_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_W-1:0]     wr_strb
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [63:0]           merged;

  always_comb merged = merge_lanes(64'(mem[wr_idx]), 64'(wr_data), 8'(wr_strb));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_WIDTH'(i);
    end else if (wr_en) begin
      mem[wr_idx] <= merged[DATA_WIDTH-1:0];
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_sram_ws.sv
// apb_sram_ws: APB3/APB4 SRAM slave with byte strobes, programmable wait
// states, a read-only low region and PSLVERR decoding.
//   PCLK, PRESET       - clock, async active-high reset
//   PSEL, PENABLE      - APB select / access phase
//   PWRITE, PADDR      - direction, byte address
//   PWDATA, PSTRB      - write data, byte-lane enables
//   PRDATA             - read data (registered at the setup edge)
//   PREADY, PSLVERR    - completion and error (combinational)
module apb_sram_ws
  import apb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int RO_WORDS    = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ERR_W-1:0]      err_cause;
  logic                  ro_hit;
  logic                  setup_take;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic                  err_q;

  assign word_addr = PADDR >> LSB;

  // With no protected region the compare would be constant, so drop it.
  if (RO_WORDS > 0) begin : g_ro
    assign ro_hit = word_addr < ADDR_WIDTH'(RO_WORDS);
  end else begin : g_no_ro
    assign ro_hit = 1'b0;
  end

  always_comb begin
    err_cause            = '0;
    err_cause[ERR_RANGE] = word_addr >= ADDR_WIDTH'(DEPTH);
    err_cause[ERR_ALIGN] = (PADDR & ADDR_WIDTH'(STRB_W - 1)) != '0;
    err_cause[ERR_RO]    = PWRITE && ro_hit;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A select seen in IDLE starts a transfer whether or not PENABLE is
  // already high, so a missing setup phase still completes.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    setup_take = 1'b0;
    PREADY     = (state == ACCESS) && PSEL && PENABLE && (cnt == 4'(WAIT_STATES));
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (PSEL) begin
          setup_take = 1'b1;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PREADY) begin
          state_nxt = IDLE;
        end else if (PENABLE) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    PSLVERR = PREADY && err_q;
    wr_en   = PREADY && write_q && !err_q;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      PRDATA  <= '0;
    end else if (setup_take) begin
      idx_q   <= word_addr[IDX_W-1:0];
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
      err_q   <= |err_cause;
      PRDATA  <= (!PWRITE && !(|err_cause)) ? rd_data : '0;
    end
  end

  apb_sram_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (PCLK),
    .rst     (PRESET),
    .rd_idx  (word_addr[IDX_W-1:0]),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_strb (strb_q)
  );

endmodule

// File: tb/tb_apb_sram_ws.sv
module tb_apb_sram_ws;

  localparam int WS    = 3;
  localparam int RO    = 4;
  localparam int DEPTH = 64;

  logic        PCLK    = 1'b0;
  logic        PRESET  = 1'b1;
  logic        psel    = 1'b0;
  logic        psel0   = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic [3:0]  pstrb   = '0;

  logic [31:0] prdata, prdata0;
  logic        pready, pready0, pslverr, pslverr0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [DEPTH];

  always #5 PCLK = ~PCLK;

  apb_sram_ws #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
    .WAIT_STATES(WS), .RO_WORDS(RO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_sram_ws #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
    .WAIT_STATES(0), .RO_WORDS(0)
  ) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  // Reference model: word memory plus error rules in byte-address terms.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'(i);
  endtask

  function automatic bit exp_err(input logic [31:0] a, input bit w);
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4)) || (w && a < 32'(RO * 4));
  endfunction

  task automatic model_apply(input logic [31:0] a, input bit w, input logic [31:0] wd,
                             input logic [3:0] st, output logic [31:0] rd, output bit err);
    err = exp_err(a, w);
    rd  = '0;
    if (!err) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) mdl[a >> 2][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = mdl[a >> 2];
      end
    end
  endtask

  // Full setup + access transfer on the main DUT; waits = access cycles
  // observed with PREADY low before completion.
  task automatic apb_xfer(input logic [31:0] a, input bit w, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd,
                          output bit err, output int waits);
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = st;
    @(negedge PCLK);
    penable = 1'b1;
    #1;
    waits = 0;
    while (!pready && waits < 40) begin
      @(negedge PCLK); #1;
      waits++;
    end
    rd  = prdata;
    err = pslverr;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge PCLK);
    #1;
    checks++;
    if (pready !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", pready); end
    checks++;
    if (pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
    checks++;
    if (prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
  endtask

  task automatic test_zero_wait();
    @(negedge PCLK);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h14; pstrb = 4'hF;
    @(negedge PCLK);
    penable = 1'b1;
    #1;
    checks++;
    if (pready0 !== 1'b1) begin failures++; $display("FAIL ws0_pready got=%b exp=1", pready0); end
    checks++;
    if (prdata0 !== 32'h5) begin failures++; $display("FAIL ws0_prdata got=%h exp=00000005", prdata0); end
    checks++;
    if (pslverr0 !== 1'b0) begin failures++; $display("FAIL ws0_pslverr got=%b exp=0", pslverr0); end
    @(posedge PCLK); #1;
    psel0 = 1'b0; penable = 1'b0;
    @(negedge PCLK); #1;
    checks++;
    if (pready0 !== 1'b0) begin failures++; $display("FAIL ws0_done got=%b exp=0", pready0); end
  endtask

  task automatic test_wait_strobe();
    logic [31:0] rd, erd;
    bit err, eerr;
    int waits;
    apb_xfer(32'h20, 1'b1, 32'hDEADBEEF, 4'b0101, rd, err, waits);
    model_apply(32'h20, 1'b1, 32'hDEADBEEF, 4'b0101, erd, eerr);
    checks++;
    if (waits !== WS) begin failures++; $display("FAIL strobe_wr_waits got=%0d exp=%0d", waits, WS); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL strobe_wr_err got=%b exp=0", err); end
    apb_xfer(32'h20, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (waits !== WS) begin failures++; $display("FAIL strobe_rd_waits got=%0d exp=%0d", waits, WS); end
    checks++;
    if (rd !== 32'h00AD00EF) begin failures++; $display("FAIL strobe_rd_data got=%h exp=00ad00ef", rd); end
  endtask

  task automatic test_protect_and_range();
    logic [31:0] rd, erd;
    bit err, eerr;
    int waits;
    apb_xfer(32'h08, 1'b1, 32'h12345678, 4'hF, rd, err, waits);
    model_apply(32'h08, 1'b1, 32'h12345678, 4'hF, erd, eerr);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL ro_wr_err got=%b exp=1", err); end
    apb_xfer(32'h08, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== 32'h2 || err !== 1'b0) begin failures++; $display("FAIL ro_rd got=%h/%b exp=00000002/0", rd, err); end
    apb_xfer(32'h0C, 1'b1, 32'hFFFFFFFF, 4'hF, rd, err, waits);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL ro_last_err got=%b exp=1", err); end
    apb_xfer(32'h10, 1'b1, 32'hCAFEF00D, 4'hF, rd, err, waits);
    model_apply(32'h10, 1'b1, 32'hCAFEF00D, 4'hF, erd, eerr);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL rw_first_err got=%b exp=0", err); end
    apb_xfer(32'h400, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL range_rd got=%h/%b exp=00000000/1", rd, err); end
    apb_xfer(32'h03, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin failures++; $display("FAIL align_rd got=%h/%b exp=00000000/1", rd, err); end
    apb_xfer(32'h100, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL range_edge got=%b exp=1", err); end
    apb_xfer(32'hFC, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== mdl[63] || err !== 1'b0) begin failures++; $display("FAIL last_word got=%h/%b exp=%h/0", rd, err, mdl[63]); end
    repeat (3) @(negedge PCLK);
    #1;
    checks++;
    if (prdata !== mdl[63]) begin failures++; $display("FAIL prdata_hold got=%h exp=%h", prdata, mdl[63]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, wd;
    bit err, eerr;
    int waits;
    wd = $urandom;
    apb_xfer(32'h40, 1'b1, wd, 4'hF, rd, err, waits);
    model_apply(32'h40, 1'b1, wd, 4'hF, erd, eerr);
    apb_xfer(32'h40, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== wd) begin failures++; $display("FAIL b2b_rd got=%h exp=%h", rd, wd); end
    apb_xfer(32'h44, 1'b1, 32'h0, 4'h0, rd, err, waits);
    apb_xfer(32'h44, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== mdl[17] || err !== 1'b0) begin failures++; $display("FAIL strb0_noop got=%h exp=%h", rd, mdl[17]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bit err;
    int waits;
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
      failures++;
      $display("FAIL midrst_out got=%b/%b/%h exp=0/0/0", pready, pslverr, prdata);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    model_reset();
    apb_xfer(32'h10, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== 32'h4) begin failures++; $display("FAIL midrst_rd got=%h exp=00000004", rd); end
    apb_xfer(32'h20, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== 32'h8) begin failures++; $display("FAIL reinit_rd got=%h exp=00000008", rd); end
  endtask

  task automatic test_abort_and_missing_setup();
    logic [31:0] rd;
    bit err;
    int waits, seen, n;
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    psel = 1'b0; penable = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK); #1;
      if (pready) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_pready got=%0d exp=0", seen); end
    apb_xfer(32'h30, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++;
    if (rd !== mdl[12]) begin failures++; $display("FAIL abort_mem got=%h exp=%h", rd, mdl[12]); end

    @(negedge PCLK);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h14;
    @(negedge PCLK); #1;
    n = 0;
    while (!pready && n < 40) begin
      @(negedge PCLK); #1;
      n++;
    end
    checks++;
    if (n !== WS) begin failures++; $display("FAIL nosetup_waits got=%0d exp=%0d", n, WS); end
    checks++;
    if (prdata !== mdl[5] || pslverr !== 1'b0) begin
      failures++;
      $display("FAIL nosetup_rd got=%h/%b exp=%h/0", prdata, pslverr, mdl[5]);
    end
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, erd;
    logic [3:0]  st;
    bit w, err, eerr;
    int waits, sel;
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else               a = $urandom;
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      apb_xfer(a, w, wd, st, rd, err, waits);
      model_apply(a, w, wd, st, erd, eerr);
      checks++;
      if (err !== eerr || rd !== erd || waits !== WS) begin
        failures++;
        $display("FAIL rand_%0d addr=%h wr=%b got=%h/%b/%0d exp=%h/%b/%0d",
                 t, a, w, rd, err, waits, erd, eerr, WS);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_wait();
    test_wait_strobe();
    test_protect_and_range();
    test_back_to_back();
    test_reset_mid();
    test_abort_and_missing_setup();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/apb_sram_ws.md
Name: apb_sram_ws

Overview:
- Parametrised APB3/APB4 SRAM slave, next generation of the team's fixed-size APB memory slave.
- Adds configurable depth and data width, byte-lane write strobes and programmable wait states.
- Adds a read-only low region and full PSLVERR decoding (range, alignment, write-protect).
- Sits behind the APB interconnect as a scratch/config memory target for the UVM APB agent.

Parameters:
- ADDR_WIDTH, 32, PADDR width (byte address).
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 8, 16, 32, 64.
- DEPTH, 64, number of DATA_WIDTH words; power of two, at least 2.
- WAIT_STATES, 0, extra access-phase cycles before PREADY; range 0..15.
- RO_WORDS, 0, words [0, RO_WORDS) are read-only; 0 disables protection.

Ports:
- PCLK  in  1  APB clock.
- PRESET  in  1  asynchronous active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write enables.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.

Behaviour:
- Interface (decided): reset PRESET, asynchronous, active-high; clock PCLK. All state is on the PCLK rising edge.
- Word index is PADDR >> log2(DATA_WIDTH/8).
- FSM has two states, IDLE and ACCESS, plus wait counter cnt (4 bits).
- Setup cycle: when PSEL=1 and PENABLE=0 in IDLE, at the edge:
  - state -> ACCESS, cnt <= 0.
  - Latch address, direction, PWDATA, PSTRB and the error flag.
  - PRDATA <= mem[idx] if a read with no error, otherwise 0.
- PREADY is combinational: PREADY = (state==ACCESS) && PSEL && PENABLE && (cnt==WAIT_STATES). With WAIT_STATES=0 the transfer takes 2 cycles (setup + 1 access).
- In ACCESS with PSEL=PENABLE=1 and cnt<WAIT_STATES: cnt increments each edge.
- Completion edge (PREADY=1):
  - Write without error: commit each byte lane b where PSTRB[b]=1. PSTRB=0 is a legal no-op.
  - state -> IDLE.
- Error flag is set by any of:
  - idx >= DEPTH;
  - low address bits not zero (misaligned);
  - write with idx < RO_WORDS.
  - Erroring writes leave memory unchanged. Erroring reads return PRDATA=0.
- PSLVERR = PREADY && error flag; otherwise 0.
- Back-to-back: a new setup cycle may follow the completion edge directly. A read of an address written in the previous transfer returns the new data.
- PSEL deasserted while in ACCESS: abort, state -> IDLE, no write, PREADY stays 0.
- PSEL=PENABLE=1 seen in IDLE (missing setup): treat as a setup cycle (latch, go to ACCESS). The transfer completes WAIT_STATES+1 cycles later; no hang.
- Reset, including mid-transfer:
  - state=IDLE, cnt=0, PRDATA=0, PREADY=0, PSLVERR=0.
  - mem[i]=i (zero-extended) for all i.
  - Any in-flight write is discarded.
- Reads ignore PSTRB. PRDATA holds its value outside transfers until the next setup.

Decomposition:
- apb_sram_pkg:
  - state enum (IDLE, ACCESS);
  - error-cause localparams (ERR_RANGE, ERR_ALIGN, ERR_RO) for coverage;
  - helper function for the byte-lane merge.
- Sub-module apb_sram_mem: DEPTH x DATA_WIDTH flop array with async reset init (mem[i]=i), combinational read port, byte-strobed write port.
- apb_sram_ws holds the FSM, wait counter, address decode and error logic.

Test Plan:
- Reset, then read word 5 (PADDR=0x14), WAIT_STATES=0 -> PREADY high in the cycle after setup, PRDATA=0x00000005, PSLVERR=0.
- WAIT_STATES=3: write 0xDEADBEEF to 0x20 with PSTRB=4'b0101, then read it back -> PREADY high on the 4th access cycle; PRDATA=0x00AD00EF (old bytes zero, since mem[8]=8 means bytes 3 and 1 were 0x00).
- RO_WORDS=4: write 0x12345678 to 0x08 -> PSLVERR=1 with PREADY; readback returns 0x00000002.
- Read 0x400 (DEPTH=64) -> PSLVERR=1, PRDATA=0. Read 0x03 -> PSLVERR=1 (misaligned).
- Assert PRESET during the wait states of a write to 0x10 -> outputs 0 immediately; after reset, read 0x10 returns 0x00000004.
- Drop PSEL mid-access on a write -> no PREADY, memory unchanged. Then PSEL=PENABLE=1 with no setup cycle -> transfer completes after WAIT_STATES+1 cycles.
